// File: rtl/escalonador_tiros_if.sv
// Offer handshake between the enemy shot scheduler and the fleet's shot logic.
interface escalonador_tiros_if;
    logic       disparo_valid;
    logic [4:0] disparo_id;
    logic       disparo_ready;

    modport master (output disparo_valid, output disparo_id, input disparo_ready);
    modport slave  (input disparo_valid, input disparo_id, output disparo_ready);
endinterface

// File: rtl/escalonador_tiros.sv
// Enemy shot scheduler: picks the next live enemy to fire, enforces a fire
// cadence and a cap on enemy shots in flight, and offers the chosen index
// through a valid/ready handshake.
// Optional feature: define ESCALONADOR_ALEATORIO_EN to start each search at a
// pseudo-random index taken from an 8-bit LFSR instead of plain round-robin.
module escalonador_tiros #(
    parameter int unsigned N_INIMIGOS = 20,
    parameter int unsigned CADENCIA   = 25_000_000,
    parameter int unsigned MAX_TIROS  = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  pausa,
    input  logic                  reiniciarJogo,
    input  logic [N_INIMIGOS-1:0] vivo,
    input  logic                  tiro_fim,
    escalonador_tiros_if.master   disparo,
    output logic [1:0]            tiros_ativos
);

    localparam int unsigned ID_W  = 5;
    localparam int unsigned CNT_W = (CADENCIA > 1) ? $clog2(CADENCIA) : 1;

    localparam logic [CNT_W-1:0] CNT_RECARGA = CNT_W'(CADENCIA - 1);
    localparam logic [ID_W-1:0]  ID_ULTIMO   = ID_W'(N_INIMIGOS - 1);
    localparam logic [1:0]       TIROS_MAX   = 2'(MAX_TIROS);

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        BUSCA  = 2'd1,
        OFERTA = 2'd2
    } estado_t;

    estado_t          estado_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  scanned_q;
    logic [ID_W-1:0]  id_q;
    logic             valid_q;
    logic [1:0]       tiros_q;
    logic [1:0]       tiros_d;

    logic             concede;
    logic [ID_W-1:0]  ptr_inc;
    logic [ID_W-1:0]  id_inc;
    logic [ID_W-1:0]  ptr_inicio;

    // A grant needs a visible offer, an accepting consumer and no pause.
    assign concede = (estado_q == OFERTA) && valid_q && disparo.disparo_ready && !pausa;
    assign ptr_inc = (ptr_q == ID_ULTIMO) ? '0 : ptr_q + ID_W'(1);
    assign id_inc  = (id_q  == ID_ULTIMO) ? '0 : id_q  + ID_W'(1);

`ifdef ESCALONADOR_ALEATORIO_EN
    logic [7:0] lfsr_q;

    // LFSR x^8+x^6+x^5+x^4+1, advancing on every unpaused cycle.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 8'hA5;
        end else if (reiniciarJogo) begin
            lfsr_q <= 8'hA5;
        end else if (!pausa) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign ptr_inicio = ID_W'(32'(lfsr_q) % N_INIMIGOS);
`else
    assign ptr_inicio = ptr_q;
`endif

    // Shots in flight: +1 on grant, -1 on tiro_fim, saturating at both ends.
    always_comb begin
        tiros_d = tiros_q;
        unique case ({concede, tiro_fim})
            2'b10:   if (tiros_q != TIROS_MAX) tiros_d = tiros_q + 2'd1;
            2'b01:   if (tiros_q != 2'd0)      tiros_d = tiros_q - 2'd1;
            default: tiros_d = tiros_q;
        endcase
    end

    // Cadence / search / offer state machine with registered outputs.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            estado_q  <= ESPERA;
            cnt_q     <= CNT_RECARGA;
            ptr_q     <= '0;
            scanned_q <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
            tiros_q   <= 2'd0;
        end else if (reiniciarJogo) begin
            estado_q  <= ESPERA;
            cnt_q     <= CNT_RECARGA;
            ptr_q     <= '0;
            scanned_q <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
            tiros_q   <= 2'd0;
        end else begin
            tiros_q <= tiros_d;
            if (pausa) begin
                valid_q <= 1'b0;
            end else begin
                unique case (estado_q)
                    ESPERA: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end else if (tiros_q < TIROS_MAX) begin
                            estado_q  <= BUSCA;
                            scanned_q <= '0;
                            ptr_q     <= ptr_inicio;
                        end
                    end
                    BUSCA: begin
                        if (vivo[ptr_q]) begin
                            id_q     <= ptr_q;
                            valid_q  <= 1'b1;
                            estado_q <= OFERTA;
                        end else begin
                            ptr_q <= ptr_inc;
                            if (scanned_q == ID_ULTIMO) begin
                                // Whole fleet examined without a live enemy.
                                estado_q <= ESPERA;
                                cnt_q    <= CNT_RECARGA;
                            end else begin
                                scanned_q <= scanned_q + ID_W'(1);
                            end
                        end
                    end
                    OFERTA: begin
                        if (concede) begin
                            valid_q  <= 1'b0;
                            ptr_q    <= id_inc;
                            cnt_q    <= CNT_RECARGA;
                            estado_q <= ESPERA;
                        end else if (!vivo[id_q]) begin
                            // Offered enemy died before acceptance: retract and keep searching.
                            valid_q   <= 1'b0;
                            ptr_q     <= id_inc;
                            scanned_q <= '0;
                            estado_q  <= BUSCA;
                        end else begin
                            valid_q <= 1'b1;
                        end
                    end
                    default: begin
                        estado_q <= ESPERA;
                        valid_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign disparo.disparo_valid = valid_q;
    assign disparo.disparo_id    = id_q;
    assign tiros_ativos          = tiros_q;

endmodule

// File: tb/tb_escalonador_tiros.sv
// Bench for escalonador_tiros: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the scheduling rules.
module tb_escalonador_tiros;

    localparam int N    = 20;
    localparam int CAD  = 4;
    localparam int MAXT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         pausa;
    logic         reiniciarJogo;
    logic         tiro_fim;
    logic [N-1:0] vivo;
    logic [1:0]   tiros_ativos;

    escalonador_tiros_if bus ();

    escalonador_tiros #(
        .N_INIMIGOS (N),
        .CADENCIA   (CAD),
        .MAX_TIROS  (MAXT)
    ) dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .pausa         (pausa),
        .reiniciarJogo (reiniciarJogo),
        .vivo          (vivo),
        .tiro_fim      (tiro_fim),
        .disparo       (bus),
        .tiros_ativos  (tiros_ativos)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int g_count = 0;
    int g_last_id = -1;

    // Behavioural model: cooldown remaining, search progress, pending offer.
    int m_cool;
    bit m_hunting;
    bit m_offering;
    int m_pos;
    int m_tried;
    int m_id;
    int m_flight;
    bit m_valid;
`ifdef ESCALONADOR_ALEATORIO_EN
    logic [7:0] m_lfsr;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    function automatic int lfsr_after(input int n);
        logic [7:0] s;
        s = 8'hA5;
        for (int k = 0; k < n; k++) s = lfsr_next(s);
        return int'(s);
    endfunction
`endif

    task automatic model_reset();
        m_cool     = CAD - 1;
        m_hunting  = 1'b0;
        m_offering = 1'b0;
        m_pos      = 0;
        m_tried    = 0;
        m_id       = 0;
        m_flight   = 0;
        m_valid    = 1'b0;
`ifdef ESCALONADOR_ALEATORIO_EN
        m_lfsr     = 8'hA5;
`endif
    endtask

    // Advance the model by one clock edge using the inputs present before it.
    task automatic model_edge();
        bit grant;
        int fl;
        int start;
        if (reiniciarJogo) begin
            model_reset();
            return;
        end
        grant = m_offering && m_valid && (bus.disparo_ready == 1'b1) && !pausa;
        fl = m_flight + (grant ? 1 : 0) - ((tiro_fim == 1'b1) ? 1 : 0);
        if (fl < 0) fl = 0;
        if (fl > MAXT) fl = MAXT;
        start = m_pos;
`ifdef ESCALONADOR_ALEATORIO_EN
        start = int'(m_lfsr) % N;
        if (!pausa) m_lfsr = lfsr_next(m_lfsr);
`endif
        if (pausa) begin
            m_valid = 1'b0;
        end else if (m_offering) begin
            if (grant) begin
                m_valid    = 1'b0;
                m_offering = 1'b0;
                m_pos      = (m_id + 1) % N;
                m_cool     = CAD - 1;
            end else if (vivo[m_id] == 1'b0) begin
                m_valid    = 1'b0;
                m_offering = 1'b0;
                m_hunting  = 1'b1;
                m_tried    = 0;
                m_pos      = (m_id + 1) % N;
            end else begin
                m_valid = 1'b1;
            end
        end else if (m_hunting) begin
            if (vivo[m_pos] == 1'b1) begin
                m_id       = m_pos;
                m_valid    = 1'b1;
                m_hunting  = 1'b0;
                m_offering = 1'b1;
            end else begin
                m_pos = (m_pos + 1) % N;
                if (m_tried == N - 1) begin
                    m_hunting = 1'b0;
                    m_cool    = CAD - 1;
                end else begin
                    m_tried++;
                end
            end
        end else begin
            if (m_cool > 0) begin
                m_cool--;
            end else if (m_flight < MAXT) begin
                m_hunting = 1'b1;
                m_tried   = 0;
                m_pos     = start;
            end
        end
        m_flight = fl;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock: note any handshake, step the model, then compare after the edge.
    task automatic tick();
        if (reset && !reiniciarJogo && !pausa && bus.disparo_valid === 1'b1
            && bus.disparo_ready === 1'b1) begin
            g_count++;
            g_last_id = int'(bus.disparo_id);
        end
        model_edge();
        @(posedge clk);
        #1;
        chk("valid", 32'(bus.disparo_valid), 32'(m_valid));
        chk("id",    32'(bus.disparo_id),    32'(m_id));
        chk("tiros", 32'(tiros_ativos),      32'(m_flight));
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (bus.disparo_valid !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        chk("wait_valid", 32'(bus.disparo_valid), 32'd1);
    endtask

    task automatic restart();
        reiniciarJogo = 1'b1;
        tick();
        reiniciarJogo = 1'b0;
    endtask

    initial begin
        int cyc;
        int seen;
        reset             = 1'b0;
        pausa             = 1'b0;
        reiniciarJogo     = 1'b0;
        tiro_fim          = 1'b0;
        vivo              = '1;
        bus.disparo_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.disparo_valid), 32'd0);
        chk("rst_id",    32'(bus.disparo_id),    32'd0);
        chk("rst_tiros", 32'(tiros_ativos),      32'd0);
        reset = 1'b1;

`ifdef ESCALONADOR_ALEATORIO_EN
        // Random start: first offer follows the reference LFSR sequence.
        repeat (5) tick();
        chk("rnd_first_valid", 32'(bus.disparo_valid), 32'd1);
        chk("rnd_first_id",    32'(bus.disparo_id),    32'(lfsr_after(3) % N));
`else
        // All alive, always ready: two grants, then capped.
        bus.disparo_ready = 1'b1;
        repeat (5) tick();
        chk("t1_first_valid", 32'(bus.disparo_valid), 32'd1);
        chk("t1_first_id",    32'(bus.disparo_id),    32'd0);
        g_count = 0;
        repeat (30) tick();
        chk("t1_grants",  32'(g_count),        32'd2);
        chk("t1_last_id", 32'(g_last_id),      32'd1);
        chk("t1_tiros",   32'(tiros_ativos),   32'd2);
        chk("t1_capped",  32'(bus.disparo_valid), 32'd0);

        // One shot ends: the next offer appears with the next index.
        bus.disparo_ready = 1'b0;
        tiro_fim = 1'b1;
        tick();
        tiro_fim = 1'b0;
        chk("t1_tiros_after_fim", 32'(tiros_ativos), 32'd1);
        wait_valid(10, cyc);
        chk("t1_third_id", 32'(bus.disparo_id), 32'd2);

        // Held offer stays stable, then retracts when the enemy dies.
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t4_hold_valid", 32'(bus.disparo_valid), 32'd1);
            chk("t4_hold_id",    32'(bus.disparo_id),    32'd2);
        end
        vivo[2] = 1'b0;
        tick();
        chk("t4_retract", 32'(bus.disparo_valid), 32'd0);
        tick();
        chk("t4_next_valid", 32'(bus.disparo_valid), 32'd1);
        chk("t4_next_id",    32'(bus.disparo_id),    32'd3);
        bus.disparo_ready = 1'b1;
        tick();
        bus.disparo_ready = 1'b0;
        chk("t4_tiros", 32'(tiros_ativos), 32'd2);

        // Grant and tiro_fim together; tiro_fim at zero saturates.
        tiro_fim = 1'b1;
        tick();
        tiro_fim = 1'b0;
        wait_valid(20, cyc);
        chk("t5_id", 32'(bus.disparo_id), 32'd4);
        bus.disparo_ready = 1'b1;
        tiro_fim = 1'b1;
        tick();
        bus.disparo_ready = 1'b0;
        chk("t5_same_cycle", 32'(tiros_ativos), 32'd1);
        tick();
        chk("t5_dec", 32'(tiros_ativos), 32'd0);
        tick();
        tiro_fim = 1'b0;
        chk("t5_sat", 32'(tiros_ativos), 32'd0);

        // Asynchronous reset while an offer is pending.
        wait_valid(30, cyc);
        bus.disparo_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.disparo_valid), 32'd0);
        chk("ar_tiros", 32'(tiros_ativos),      32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        bus.disparo_ready = 1'b0;
        chk("ar_no_grant", 32'(tiros_ativos), 32'd0);

        // Pause during cooldown, pause during offer, restart during offer.
        vivo = '1;
        restart();
        repeat (2) tick();
        pausa = 1'b1;
        repeat (5) tick();
        pausa = 1'b0;
        repeat (2) tick();
        chk("t6_cnt_frozen", 32'(bus.disparo_valid), 32'd0);
        tick();
        chk("t6_valid", 32'(bus.disparo_valid), 32'd1);
        chk("t6_id",    32'(bus.disparo_id),    32'd0);
        pausa = 1'b1;
        bus.disparo_ready = 1'b1;
        tick();
        chk("t6_pause_drop", 32'(bus.disparo_valid), 32'd0);
        tick();
        chk("t6_pause_nogrant", 32'(tiros_ativos), 32'd0);
        pausa = 1'b0;
        bus.disparo_ready = 1'b0;
        tick();
        chk("t6_resume_valid", 32'(bus.disparo_valid), 32'd1);
        chk("t6_resume_id",    32'(bus.disparo_id),    32'd0);
        bus.disparo_ready = 1'b1;
        tick();
        bus.disparo_ready = 1'b0;
        chk("t6_grant", 32'(tiros_ativos), 32'd1);
        wait_valid(20, cyc);
        chk("t6_id1", 32'(bus.disparo_id), 32'd1);
        restart();
        chk("t6_restart_valid", 32'(bus.disparo_valid), 32'd0);
        chk("t6_restart_tiros", 32'(tiros_ativos),      32'd0);
        wait_valid(20, cyc);
        chk("t6_restart_ptr", 32'(bus.disparo_id), 32'd0);

        // Single live enemy: wrap-around scan returns to it.
        vivo = '0;
        vivo[7] = 1'b1;
        restart();
        wait_valid(40, cyc);
        chk("t2_lat", 32'(cyc), 32'd12);
        chk("t2_id",  32'(bus.disparo_id), 32'd7);
        bus.disparo_ready = 1'b1;
        tick();
        bus.disparo_ready = 1'b0;
        wait_valid(60, cyc);
        chk("t2_wrap_lat", 32'(cyc), 32'd24);
        chk("t2_wrap_id",  32'(bus.disparo_id), 32'd7);

        // Empty fleet: full scan, then cooldown reload before the next search.
        vivo = '0;
        restart();
        seen = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (bus.disparo_valid !== 1'b0) seen++;
        end
        chk("t3_never_valid", 32'(seen), 32'd0);
        vivo = '1;
        wait_valid(30, cyc);
        chk("t3_reload_lat", 32'(cyc), 32'd5);
        chk("t3_id",         32'(bus.disparo_id), 32'd0);
`endif

        // Randomized traffic against the model.
        restart();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) pausa = ~pausa;
            reiniciarJogo     = ($urandom_range(0, 199) == 0);
            tiro_fim          = ($urandom_range(0, 7) == 0);
            bus.disparo_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 24) == 0) begin
                case ($urandom_range(0, 3))
                    0: vivo = '0;
                    1: begin
                        vivo = '0;
                        vivo[$urandom_range(0, N - 1)] = 1'b1;
                    end
                    default: vivo = N'($urandom);
                endcase
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
